updown_mod_counter: RTL and testbench
=====================================

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 Parameter WIDTH, default 3: counter width in bits, legal range 2..16.
REQ-002 Parameter MODULUS, default 8: count range 0..MODULUS-1, legal range 2..2**WIDTH.
REQ-003 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port en, input, 1: count enable; 1 = one step per clock.
REQ-006 Port up, input, 1: direction; 1 = increment, 0 = decrement.
REQ-007 Port sat, input, 1: boundary mode; 1 = saturate at boundary, 0 = wrap modulo MODULUS.
REQ-008 Port clr, input, 1: synchronous clear to 0.
REQ-009 Port counter, output, WIDTH: registered count value.
REQ-010 Port y, output, 1: combinational terminal-count flag.
REQ-011 Port wrap, output, 1: registered one-cycle pulse marking a completed wrap.
REQ-012 Port wrap_cnt, output, 8: registered count of wraps since reset or clr.

Function
REQ-013 Update priority each clock: clr, then load (REQ-027), then en; with none active, all state holds.
REQ-014 clr=1: counter<=0, wrap_cnt<=0, wrap<=0, regardless of en, up, sat.
REQ-015 en=1, up=1, counter<MODULUS-1: counter<=counter+1.
REQ-016 en=1, up=0, counter>0: counter<=counter-1.
REQ-017 en=1, up=1, counter==MODULUS-1, sat=0: counter<=0, wrap<=1 next cycle, wrap_cnt increments.
REQ-018 en=1, up=0, counter==0, sat=0: counter<=MODULUS-1, wrap<=1 next cycle, wrap_cnt increments.
REQ-019 en=1 at the boundary with sat=1: counter holds, wrap<=0, wrap_cnt unchanged.
REQ-020 wrap is 1 for exactly one cycle per wrap event; consecutive wraps (MODULUS=2 case) hold wrap=1 on consecutive cycles.
REQ-021 wrap_cnt saturates at 255 and never rolls over.
REQ-022 y = (up && counter==MODULUS-1) || (!up && counter==0); y is independent of en and sat.
REQ-023 Changing up, sat or en on any cycle takes effect on that same clock edge; no pipeline latency.
REQ-024 counter never holds a value >= MODULUS under any input sequence.
REQ-025 When MODULUS==2**WIDTH, wrap arithmetic uses natural WIDTH-bit overflow, with results identical to REQ-017/018.

Reset
REQ-026 reset=0 asynchronously forces counter=0, wrap=0, wrap_cnt=0 (and load-path state, if present); asserting reset mid-count aborts the count immediately; first update occurs on the first rising clk after reset returns to 1.

Configuration
REQ-027 Macro UPDOWN_CNT_LOAD_EN defined: adds inputs load (1 bit) and din (WIDTH bits); load=1 sets counter<=din, or MODULUS-1 if din>=MODULUS; a load never pulses wrap and never changes wrap_cnt.
REQ-028 Macro UPDOWN_CNT_LOAD_EN undefined: load and din ports do not exist, and the priority is clr then en.

Verification
REQ-029 Defaults, reset 0->1, en=1 up=1 sat=0 for 10 clocks -> counter 1..7,0,1,2; wrap high one cycle after 7->0; wrap_cnt=1; y=1 while counter=7.
REQ-030 MODULUS=5, en=1 up=0 sat=0 from 0 -> counter 4,3,2,1,0,4; wrap pulses after each 0->4; y=1 while counter=0.
REQ-031 MODULUS=5, sat=1, up=1 for 8 clocks -> counter stops at 4 and holds, wrap never 1, wrap_cnt=0; then up=0 -> counter 3,2,1,0 then holds.
REQ-032 Counter at 6 with en=1 and clr=1 on one edge -> counter=0, wrap_cnt=0; reset pulled low between clock edges -> outputs go to 0 immediately, with no wait for clk.
REQ-033 MODULUS=2, en=1 up=1 sat=0 for 600 clocks -> wrap toggles per REQ-020, wrap_cnt stops at 255.
REQ-034 With UPDOWN_CNT_LOAD_EN, MODULUS=6: load=1 din=7 -> counter=5; load=1 din=2 with clr=1 -> counter=0; load=1 din=3 with en=1 -> counter=3, wrap=0.

Source files
------------

// File: rtl/updown_mod_counter_if.sv
// ============================================================================
// updown_mod_counter_if : control/status bundle for updown_mod_counter
// Load/din members exist only when UPDOWN_CNT_LOAD_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface updown_mod_counter_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             up;
  logic             sat;
  logic             clr;
`ifdef UPDOWN_CNT_LOAD_EN
  logic             load;
  logic [WIDTH-1:0] din;
`endif
  logic [WIDTH-1:0] counter;
  logic             y;
  logic             wrap;
  logic [7:0]       wrap_cnt;

`ifdef UPDOWN_CNT_LOAD_EN
  modport master (
    output en, up, sat, clr, load, din,
    input  counter, y, wrap, wrap_cnt
  );
  modport slave (
    input  en, up, sat, clr, load, din,
    output counter, y, wrap, wrap_cnt
  );
`else
  modport master (
    output en, up, sat, clr,
    input  counter, y, wrap, wrap_cnt
  );
  modport slave (
    input  en, up, sat, clr,
    output counter, y, wrap, wrap_cnt
  );
`endif
endinterface

`default_nettype wire

// File: rtl/updown_mod_counter.sv
// ============================================================================
// updown_mod_counter : modulo-MODULUS up/down counter, wrap/saturate, wrap
// pulse and saturating wrap count. Optional load via UPDOWN_CNT_LOAD_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module updown_mod_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  wire logic              clk,
  input  wire logic              reset,
  updown_mod_counter_if.slave    bus
);

  localparam logic [WIDTH-1:0] c_MAX    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] c_ONE    = WIDTH'(1);
  localparam logic [7:0]       c_CNT_MAX = 8'hFF;

  logic [WIDTH-1:0] counter_q, counter_d;
  logic             wrap_q, wrap_d;
  logic [7:0]       wrap_cnt_q, wrap_cnt_d;

  logic w_at_top;
  logic w_at_bot;
  logic w_at_bound;
  logic w_step_wraps;

  assign w_at_top     = (counter_q == c_MAX);
  assign w_at_bot     = (counter_q == '0);
  // Boundary in the currently selected direction; also the terminal-count flag.
  assign w_at_bound   = bus.up ? w_at_top : w_at_bot;
  assign w_step_wraps = w_at_bound && !bus.sat;

`ifdef UPDOWN_CNT_LOAD_EN
  localparam logic [WIDTH:0] c_MOD = (WIDTH+1)'(MODULUS);
  logic [WIDTH-1:0] w_din_clamped;
  assign w_din_clamped = ({1'b0, bus.din} >= c_MOD) ? c_MAX : bus.din;
`endif

  always_comb begin
    counter_d  = counter_q;
    wrap_d     = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    if (bus.clr) begin
      counter_d  = '0;
      wrap_cnt_d = '0;
    end
`ifdef UPDOWN_CNT_LOAD_EN
    else if (bus.load) begin
      counter_d = w_din_clamped;
    end
`endif
    else if (bus.en) begin
      if (w_step_wraps) begin
        // Explicit targets keep MODULUS < 2**WIDTH from escaping the range.
        counter_d = bus.up ? '0 : c_MAX;
        wrap_d    = 1'b1;
        if (wrap_cnt_q != c_CNT_MAX) begin
          wrap_cnt_d = wrap_cnt_q + 8'd1;
        end
      end else if (!w_at_bound) begin
        counter_d = bus.up ? (counter_q + c_ONE) : (counter_q - c_ONE);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter_q  <= '0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      counter_q  <= counter_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign bus.counter  = counter_q;
  assign bus.wrap     = wrap_q;
  assign bus.wrap_cnt = wrap_cnt_q;
  assign bus.y        = w_at_bound;

endmodule

`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
// ============================================================================
// tb_updown_mod_counter : directed self-checking bench, MODULUS 8 / 5 / 2
// (and 6 with load when UPDOWN_CNT_LOAD_EN is defined).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_updown_mod_counter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  updown_mod_counter_if #(.WIDTH(3)) if8 ();
  updown_mod_counter_if #(.WIDTH(3)) if5 ();
  updown_mod_counter_if #(.WIDTH(2)) if2 ();

  updown_mod_counter #(.WIDTH(3), .MODULUS(8)) u8 (.clk(clk), .reset(reset), .bus(if8.slave));
  updown_mod_counter #(.WIDTH(3), .MODULUS(5)) u5 (.clk(clk), .reset(reset), .bus(if5.slave));
  updown_mod_counter #(.WIDTH(2), .MODULUS(2)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));

`ifdef UPDOWN_CNT_LOAD_EN
  updown_mod_counter_if #(.WIDTH(3)) if6 ();
  updown_mod_counter #(.WIDTH(3), .MODULUS(6)) u6 (.clk(clk), .reset(reset), .bus(if6.slave));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One active edge, then settle away from it before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp5_c [6] = '{4, 3, 2, 1, 0, 4};
    int exp5_w [6] = '{1, 0, 0, 0, 0, 1};
    int sat_c  [8] = '{1, 2, 3, 4, 4, 4, 4, 4};
    int satd_c [6] = '{3, 2, 1, 0, 0, 0};
    int ec;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    {if8.en, if8.up, if8.sat, if8.clr} = 4'b0100;
    {if5.en, if5.up, if5.sat, if5.clr} = 4'b0100;
    {if2.en, if2.up, if2.sat, if2.clr} = 4'b0100;
`ifdef UPDOWN_CNT_LOAD_EN
    {if6.en, if6.up, if6.sat, if6.clr} = 4'b0100;
    if8.load = 1'b0; if8.din = '0;
    if5.load = 1'b0; if5.din = '0;
    if2.load = 1'b0; if2.din = '0;
    if6.load = 1'b0; if6.din = '0;
`endif
    step();
    step();
    chk_eq("rst_counter", 32'(if8.counter), 0);
    chk_eq("rst_wrap", 32'(if8.wrap), 0);
    chk_eq("rst_wrap_cnt", 32'(if8.wrap_cnt), 0);
    reset = 1'b1;

    // MODULUS 8 upward wrap
    if8.en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      ec = i % 8;
      chk_eq($sformatf("m8_up_cnt[%0d]", i), 32'(if8.counter), 32'(ec));
      chk_eq($sformatf("m8_up_wrap[%0d]", i), 32'(if8.wrap), (i == 8) ? 1 : 0);
      chk_eq($sformatf("m8_up_wcnt[%0d]", i), 32'(if8.wrap_cnt), (i >= 8) ? 1 : 0);
      chk_eq($sformatf("m8_up_y[%0d]", i), 32'(if8.y), (ec == 7) ? 1 : 0);
    end
    if8.en = 1'b0;

    // MODULUS 5 downward wrap
    if5.up = 1'b0;
    #1;
    chk_eq("m5_dn_y_at0", 32'(if5.y), 1);
    if5.en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_eq($sformatf("m5_dn_cnt[%0d]", i), 32'(if5.counter), 32'(exp5_c[i]));
      chk_eq($sformatf("m5_dn_wrap[%0d]", i), 32'(if5.wrap), 32'(exp5_w[i]));
      chk_eq($sformatf("m5_dn_y[%0d]", i), 32'(if5.y), (exp5_c[i] == 0) ? 1 : 0);
    end
    chk_eq("m5_dn_wcnt", 32'(if5.wrap_cnt), 2);
    if5.en = 1'b0;
    step();
    chk_eq("m5_idle_wrap", 32'(if5.wrap), 0);
    chk_eq("m5_idle_cnt", 32'(if5.counter), 4);

    // MODULUS 5 saturation
    if5.clr = 1'b1;
    step();
    chk_eq("m5_clr_cnt", 32'(if5.counter), 0);
    chk_eq("m5_clr_wcnt", 32'(if5.wrap_cnt), 0);
    if5.clr = 1'b0;
    if5.sat = 1'b1;
    if5.up  = 1'b1;
    if5.en  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_eq($sformatf("m5_satup_cnt[%0d]", i), 32'(if5.counter), 32'(sat_c[i]));
      chk_eq($sformatf("m5_satup_wrap[%0d]", i), 32'(if5.wrap), 0);
    end
    chk_eq("m5_satup_wcnt", 32'(if5.wrap_cnt), 0);
    chk_eq("m5_satup_y", 32'(if5.y), 1);
    if5.up = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_eq($sformatf("m5_satdn_cnt[%0d]", i), 32'(if5.counter), 32'(satd_c[i]));
      chk_eq($sformatf("m5_satdn_wrap[%0d]", i), 32'(if5.wrap), 0);
    end
    chk_eq("m5_satdn_wcnt", 32'(if5.wrap_cnt), 0);
    if5.en = 1'b0;

    // MODULUS 8: clear beats enable, then asynchronous reset mid-count
    if8.en = 1'b1;
    repeat (4) step();
    chk_eq("m8_pre_clr_cnt", 32'(if8.counter), 6);
    if8.clr = 1'b1;
    step();
    chk_eq("m8_clr_cnt", 32'(if8.counter), 0);
    chk_eq("m8_clr_wcnt", 32'(if8.wrap_cnt), 0);
    if8.clr = 1'b0;
    if8.up  = 1'b0;
    step();
    chk_eq("m8_dn_wrap_cnt", 32'(if8.counter), 7);
    chk_eq("m8_dn_wrap", 32'(if8.wrap), 1);
    chk_eq("m8_dn_wcnt", 32'(if8.wrap_cnt), 1);
    reset = 1'b0;
    #1;
    chk_eq("m8_async_cnt", 32'(if8.counter), 0);
    chk_eq("m8_async_wrap", 32'(if8.wrap), 0);
    chk_eq("m8_async_wcnt", 32'(if8.wrap_cnt), 0);
    #1;
    reset = 1'b1;
    step();
    chk_eq("m8_post_rst_cnt", 32'(if8.counter), 7);
    chk_eq("m8_post_rst_wrap", 32'(if8.wrap), 1);
    if8.en = 1'b0;
    step();
    chk_eq("m8_hold_cnt", 32'(if8.counter), 7);
    chk_eq("m8_hold_wrap", 32'(if8.wrap), 0);
    chk_eq("m8_y_dn_at7", 32'(if8.y), 0);
    if8.up = 1'b1;
    #1;
    chk_eq("m8_y_up_at7", 32'(if8.y), 1);

    // MODULUS 2: 600 wrapping steps, wrap_cnt saturation
    if2.en = 1'b1;
    for (int i = 1; i <= 600; i++) begin
      step();
      chk_eq($sformatf("m2_cnt[%0d]", i), 32'(if2.counter), 32'(i % 2));
      chk_eq($sformatf("m2_wrap[%0d]", i), 32'(if2.wrap), (i % 2 == 0) ? 1 : 0);
      chk_eq($sformatf("m2_wcnt[%0d]", i), 32'(if2.wrap_cnt), (i / 2 > 255) ? 255 : 32'(i / 2));
    end
    if2.up = 1'b0;
    step();
    chk_eq("m2_dn_cnt", 32'(if2.counter), 1);
    chk_eq("m2_dn_wrap", 32'(if2.wrap), 1);
    if2.up = 1'b1;
    step();
    chk_eq("m2_back_cnt", 32'(if2.counter), 0);
    chk_eq("m2_back_wrap", 32'(if2.wrap), 1);
    chk_eq("m2_wcnt_sat", 32'(if2.wrap_cnt), 255);
    if2.en = 1'b0;

`ifdef UPDOWN_CNT_LOAD_EN
    if6.load = 1'b1;
    if6.din  = 3'd7;
    step();
    chk_eq("m6_load_clamp", 32'(if6.counter), 5);
    chk_eq("m6_load_wrap", 32'(if6.wrap), 0);
    if6.din = 3'd2;
    if6.clr = 1'b1;
    step();
    chk_eq("m6_clr_over_load", 32'(if6.counter), 0);
    if6.clr = 1'b0;
    if6.din = 3'd3;
    if6.en  = 1'b1;
    step();
    chk_eq("m6_load_over_en", 32'(if6.counter), 3);
    chk_eq("m6_load_en_wrap", 32'(if6.wrap), 0);
    chk_eq("m6_load_wcnt", 32'(if6.wrap_cnt), 0);
    if6.load = 1'b0;
    if6.en   = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
